mux1hot_rr_arbiter: RTL and testbench
=====================================

// Module: mux1hot_rr_arbiter
// PURPOSE
//  Round-robin, packet-locking arbiter that shares one output channel among
//  NREQ valid/ready requesters. Holds a registered one-hot grant, which is
//  exported as the select for the one-hot data mux (Mux1hot family). The
//  grant stays locked on a requester until the beat flagged last is transferred.
//  Sits in front of any shared sink (bus port, FIFO, CSR bank).
// PARAMETERS
//  NREQ   8   number of requesters; legal range 2..32
//  WIDTH  32  data width per requester, in bits
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  rst        in   1           synchronous reset, active-high
//  req_valid  in   NREQ        per-requester beat valid
//  req_last   in   NREQ        per-requester last-beat-of-packet flag
//  req_data   in   NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ        per-requester beat accepted
//  out_valid  out  1           output beat valid
//  out_last   out  1           output last flag
//  out_data   out  WIDTH       output data
//  out_ready  in   1           sink accepts beat
//  grant      out  NREQ        registered one-hot grant (all zero when idle)
//  busy       out  1           1 while state is LOCKED
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, grant=0, prio_ptr=NREQ-1.
//    Requester 0 therefore has highest priority after reset.
//    Reset values of outputs: out_valid=0, req_ready=0, busy=0.
//  - FSM IDLE:
//    - If |req_valid, pick the first set req_valid scanning upward from
//      (prio_ptr+1) mod NREQ, with wrap-around.
//    - Register grant=onehot(pick) and go to LOCKED.
//    - If no request is valid, stay in IDLE.
//    - No beat transfers in IDLE, so there is a 1-cycle arbitration bubble per packet.
//  - FSM LOCKED, with g = index of the set grant bit:
//    - out_valid = req_valid[g]; out_last = req_last[g].
//    - out_data = one-hot mux of req_data by grant (combinational, same cycle).
//    - req_ready = grant & {NREQ{out_ready}}. Non-granted ready bits are 0.
//    - A beat transfers when out_valid & out_ready.
//    - A transfer with out_last=1 sets prio_ptr=g, grant=0 and state=IDLE
//      at the next edge.
//    - If the granted requester deasserts valid mid-packet, the grant is held
//      and out_valid=0. No timeout.
//    - Other requesters wait and are never starved: after a packet ends,
//      requester g has the lowest priority.
//  - Output path is fully combinational from grant and the req_* inputs.
//    Latency from the first req_valid to the first out_valid is 1 cycle.
//  - Invariant: grant is one-hot in LOCKED and zero in IDLE.
//    The bench asserts $onehot0(grant) on every cycle.
//  - Reset mid-packet: the packet is aborted, grant clears at that edge, and
//    no beat transfers in the reset cycle (out_valid is forced to 0 while rst=1).
//  - Single-beat packets (req_last=1 on the first beat) take 2 cycles each
//    (IDLE then LOCKED). Maximum throughput is 1 packet per 2 cycles.
//  - Events while LOCKED: a req_valid change on a non-granted requester has
//    no effect until IDLE. In IDLE, arbitration uses only that cycle's req_valid.
// TESTING
//  1. Reset: rst=1 for 2 cycles with all req_valid=1 -> grant=0, out_valid=0,
//     req_ready=0. First grant after release is 8'h01.
//  2. Fairness: all 8 requesters hold single-beat packets with out_ready=1 ->
//     grant sequence 01,02,04,...,80,01, a new grant every 2 cycles.
//  3. Lock: req 2 sends a 4-beat packet (last on beat 4), req 1 requests at
//     beat 2 -> req 1 is not granted until the cycle after req 2's last
//     transfer, then grant=8'h02.
//  4. Backpressure: req 5 is granted, data=32'hA5A5_0005, out_ready low for
//     3 cycles -> out_valid and out_data stable, req_ready[5]=0, grant holds.
//  5. Granted valid gap: req 3 drops valid between beats 1 and 2 of a 2-beat
//     packet -> out_valid=0 during the gap, grant stays 8'h08, beat 2 passes.
//  6. Reset mid-packet: rst asserted during beat 2 of 3 -> grant=0 next cycle,
//     prio_ptr=7, and the first grant after reset goes to the lowest active index.

Source files
------------

// File: rtl/mux1hot_rr_arbiter.sv
// Round-robin, packet-locking arbiter that shares one valid/ready output channel among NREQ
// requesters. The registered one-hot grant also acts as the select for the one-hot data mux.
module mux1hot_rr_arbiter #(
  parameter int unsigned NREQ  = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int unsigned PtrW = $clog2(NREQ);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0] prio_ptr_q, prio_ptr_d;

  logic [NREQ-1:0] pick;
  logic            pick_found;
  logic [PtrW-1:0] scan;
  logic [PtrW-1:0] grant_idx;
  logic            xfer_last;

  // Scan upward from the slot after the last winner, wrapping at NREQ-1.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan       = prio_ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = (scan == PtrW'(NREQ - 1)) ? '0 : scan + PtrW'(1);
      if (!pick_found && req_valid[scan]) begin
        pick[scan] = 1'b1;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        grant_idx = PtrW'(i);
      end
    end
  end

  // One-hot AND-OR mux; an all-zero grant yields zero data and last.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      out_data = out_data | (req_data[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}});
      out_last = out_last | (req_last[i] & grant_q[i]);
    end
  end

  // Reset masks the handshake so an aborted packet never transfers a beat.
  assign out_valid = ~rst & (|(grant_q & req_valid));
  assign req_ready = grant_q & {NREQ{out_ready & ~rst}};
  assign grant     = grant_q;
  assign busy      = (state_q == StLocked);
  assign xfer_last = out_valid & out_ready & out_last;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_ptr_d = prio_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (xfer_last) begin
          grant_d    = '0;
          prio_ptr_d = grant_idx;
          state_d    = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      prio_ptr_q <= PtrW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_ptr_q <= prio_ptr_d;
    end
  end

endmodule

// File: tb/tb_mux1hot_rr_arbiter.sv
// Randomized scoreboard bench for mux1hot_rr_arbiter: a packet-level reference model predicts
// per-cycle grant/handshake state and the ordered stream of transferred beats.
module tb_mux1hot_rr_arbiter;

  localparam int NREQ  = 8;
  localparam int WIDTH = 32;
  localparam int NCYC  = 3000;
  localparam int NSAT  = 200;

  bit                    clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_last;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  mux1hot_rr_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_data (out_data),
    .out_ready(out_ready),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]  grant;
    logic             busy;
    logic             ov;
    logic [NREQ-1:0]  rr;
    logic             chk_data;
    logic [WIDTH-1:0] data;
    logic             last;
  } cyc_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  cyc_t  cyc_q[$];
  beat_t beat_q[$];

  int vectors = 0;
  int errors  = 0;

  // Reference model: locked requester (-1 when idle), last winner, per-requester packets.
  int m_lock;
  int m_ptr;
  int rem  [NREQ];
  int pid  [NREQ];
  int beat [NREQ];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit do_rst, input bit sat);
    logic [NREQ-1:0] one;
    cyc_t            e;
    beat_t           b;
    bit              xfer;
    int              g;
    one       = 1;
    rst       = do_rst;
    out_ready = sat ? 1'b1 : ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NREQ; i++) begin
      if (rem[i] == 0 && (sat || $urandom_range(0, 2) == 0)) begin
        rem[i]  = sat ? 1 : int'($urandom_range(1, 4));
        pid[i]  = pid[i] + 1;
        beat[i] = 0;
      end
      req_valid[i] = (rem[i] != 0) && (sat || $urandom_range(0, 4) != 0);
      req_last[i]  = (rem[i] == 1);
      req_data[i*WIDTH +: WIDTH] = {8'(i), 8'(pid[i]), 8'(beat[i]), 8'($urandom)};
    end

    g          = m_lock;
    e.grant    = (g >= 0) ? (one << g) : '0;
    e.busy     = (g >= 0);
    xfer       = (g >= 0) && !do_rst && req_valid[g] && out_ready;
    e.ov       = (g >= 0) && !do_rst && req_valid[g];
    e.rr       = ((g >= 0) && !do_rst && out_ready) ? e.grant : '0;
    e.chk_data = (g >= 0);
    e.data     = '0;
    e.last     = 1'b0;
    if (g >= 0) begin
      e.data = req_data[g*WIDTH +: WIDTH];
      e.last = req_last[g];
    end
    cyc_q.push_back(e);

    if (do_rst) begin
      m_lock = -1;
      m_ptr  = NREQ - 1;
      for (int i = 0; i < NREQ; i++) rem[i] = 0;
    end else if (xfer) begin
      b.data = e.data;
      b.last = e.last;
      beat_q.push_back(b);
      beat[g] = beat[g] + 1;
      rem[g]  = rem[g] - 1;
      if (rem[g] == 0) begin
        m_ptr  = g;
        m_lock = -1;
      end
    end else if (g < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (m_lock < 0 && req_valid[idx]) m_lock = idx;
      end
    end
  endtask

  // Monitor: one expectation record per cycle, one beat record per observed transfer.
  initial begin
    cyc_t  e;
    beat_t b;
    forever begin
      @(negedge clk);
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        chk("grant", 64'(grant), 64'(e.grant));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("out_valid", 64'(out_valid), 64'(e.ov));
        chk("req_ready", 64'(req_ready), 64'(e.rr));
        chk("grant_onehot0", 64'($onehot0(grant)), 64'(1));
        if (e.chk_data) begin
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_last", 64'(out_last), 64'(e.last));
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 64'(1), 64'(0));
        end else begin
          b = beat_q.pop_front();
          chk("beat_data", 64'(out_data), 64'(b.data));
          chk("beat_last", 64'(out_last), 64'(b.last));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    m_lock    = -1;
    m_ptr     = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]  = 0;
      pid[i]  = 0;
      beat[i] = 0;
    end
    @(posedge clk);
    for (int c = 0; c < NCYC; c++) begin
      #1;
      // Saturated single-beat phase first (fairness), then random traffic with rare resets.
      step(c == 0 || (c >= NSAT && $urandom_range(0, 149) == 0), c < NSAT);
      @(posedge clk);
    end
    #1;
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("beats_left", 64'(beat_q.size()), 64'(0));
    chk("cycles_left", 64'(cyc_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
